div_avalon_mc: RTL and testbench

//  Multi-channel Avalon-MM slave integer divider; parametrised successor of the single-channel divider slave.
//  2**CHW independent radix-2 restoring dividers, each with its own register bank, done flag and irq enable.

---
 rtl/div_avalon_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_div_avalon_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_avalon_mc.sv
// Multi-channel Avalon-MM radix-2 restoring divider: 2**CHW channels, each with its own
// register bank, FSM, done/dbz flags and irq enable. Define AVDIV_SIGNED_EN for signed division.
module div_avalon_mc #(
    parameter int W    = 32,
    parameter int CBIT = 6,
    parameter int CHW  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CHW+2:0]     div_address,
    input  logic               div_chipselect,
    input  logic               div_read,
    input  logic               div_write,
    input  logic [W-1:0]       div_writedata,
    output logic [W-1:0]       div_readdata,
    output logic               div_irq,
    output logic [(1<<CHW)-1:0] div_rdy
);
    localparam int NCH = 1 << CHW;

`ifdef AVDIV_SIGNED_EN
    localparam logic SGN_EN = 1'b1;
`else
    localparam logic SGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OP, S_DONE} state_t;

    state_t          st_q  [NCH];
    state_t          st_d  [NCH];
    logic [W-1:0]    dvd_q [NCH];
    logic [W-1:0]    dvd_d [NCH];
    logic [W-1:0]    dvs_q [NCH];
    logic [W-1:0]    dvs_d [NCH];
    logic [W-1:0]    quo_q [NCH];
    logic [W-1:0]    quo_d [NCH];
    logic [W-1:0]    rem_q [NCH];
    logic [W-1:0]    rem_d [NCH];
    logic [W-1:0]    a_q   [NCH];
    logic [W-1:0]    a_d   [NCH];
    logic [W-1:0]    b_q   [NCH];
    logic [W-1:0]    b_d   [NCH];
    logic [W-1:0]    acc_q [NCH];
    logic [W-1:0]    acc_d [NCH];
    logic [CBIT-1:0] cnt_q [NCH];
    logic [CBIT-1:0] cnt_d [NCH];
    logic [W:0]      part  [NCH];
    logic [W:0]      diff  [NCH];

    logic [NCH-1:0]  ie_q, ie_d, done_q, done_d, dbz_q, dbz_d, sgn_q, sgn_d;
    logic [NCH-1:0]  negq_q, negq_d, negr_q, negr_d, rdy_q, rdy_d;
    logic [W-1:0]    rdata_q, rdata_d;
    logic            irq_q, irq_d;

    logic [CHW-1:0]  sel_ch;
    logic [2:0]      sel_reg;
    logic            wr_en, rd_en;

    assign sel_ch  = div_address[CHW+2:3];
    assign sel_reg = div_address[2:0];
    assign wr_en   = div_chipselect & div_write;
    assign rd_en   = div_chipselect & div_read;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? -x : x;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    // Trial subtraction; with acc < divisor the difference fits in W bits, so bit W is the borrow.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            part[c] = {acc_q[c], a_q[c][W-1]};
            diff[c] = part[c] - {1'b0, b_q[c]};
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        irq_d   = |(done_q & ie_q);
        ie_d    = ie_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rdy_d   = rdy_q;
        for (int c = 0; c < NCH; c++) begin
            st_d[c]  = st_q[c];
            dvd_d[c] = dvd_q[c];
            dvs_d[c] = dvs_q[c];
            quo_d[c] = quo_q[c];
            rem_d[c] = rem_q[c];
            a_d[c]   = a_q[c];
            b_d[c]   = b_q[c];
            acc_d[c] = acc_q[c];
            cnt_d[c] = cnt_q[c];

            if (wr_en && sel_ch == CHW'(c)) begin
                case (sel_reg)
                    3'd0: dvd_d[c] = div_writedata;
                    3'd1: dvs_d[c] = div_writedata;
                    3'd2: begin
                        if (div_writedata[0] && st_q[c] == S_IDLE) begin
                            st_d[c]  = S_LOAD;
                            a_d[c]   = dvd_q[c];
                            b_d[c]   = dvs_q[c];
                            sgn_d[c] = div_writedata[1] & SGN_EN;
                            done_d[c] = 1'b0;
                            dbz_d[c]  = 1'b0;
                            rdy_d[c]  = 1'b0;
                        end
                    end
                    3'd5: ie_d[c] = div_writedata[0];
                    default: ;
                endcase
            end

            // Engine registers belong to the FSM; bank writes above never touch them while busy.
            case (st_q[c])
                S_LOAD: begin
                    a_d[c]    = magnitude(a_q[c], sgn_q[c]);
                    b_d[c]    = magnitude(b_q[c], sgn_q[c]);
                    negq_d[c] = sgn_q[c] & (a_q[c][W-1] ^ b_q[c][W-1]);
                    negr_d[c] = sgn_q[c] & a_q[c][W-1];
                    dbz_d[c]  = (b_q[c] == '0);
                    acc_d[c]  = '0;
                    cnt_d[c]  = CBIT'(W);
                    st_d[c]   = S_OP;
                end
                S_OP: begin
                    if (!diff[c][W]) begin
                        acc_d[c] = diff[c][W-1:0];
                        a_d[c]   = {a_q[c][W-2:0], 1'b1};
                    end else begin
                        acc_d[c] = part[c][W-1:0];
                        a_d[c]   = {a_q[c][W-2:0], 1'b0};
                    end
                    cnt_d[c] = cnt_q[c] - CBIT'(1);
                    if (cnt_q[c] == CBIT'(1)) st_d[c] = S_DONE;
                end
                S_DONE: begin
                    // Divide-by-zero falls out naturally: all-ones magnitude and R = |A| re-signed.
                    quo_d[c]  = apply_sign(a_q[c], negq_q[c]);
                    rem_d[c]  = apply_sign(acc_q[c], negr_q[c]);
                    done_d[c] = 1'b1;
                    rdy_d[c]  = 1'b1;
                    st_d[c]   = S_IDLE;
                end
                default: ;
            endcase
        end

        if (rd_en) begin
            case (sel_reg)
                3'd0: rdata_d = dvd_q[sel_ch];
                3'd1: rdata_d = dvs_q[sel_ch];
                3'd2: begin
                    rdata_d      = '0;
                    rdata_d[3:0] = {sgn_q[sel_ch], dbz_q[sel_ch], done_q[sel_ch], rdy_q[sel_ch]};
                end
                3'd3: rdata_d = quo_q[sel_ch];
                3'd4: rdata_d = rem_q[sel_ch];
                3'd5: begin
                    rdata_d    = '0;
                    rdata_d[0] = ie_q[sel_ch];
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                st_q[c]  <= S_IDLE;
                dvd_q[c] <= '0;
                dvs_q[c] <= '0;
                quo_q[c] <= '0;
                rem_q[c] <= '0;
                a_q[c]   <= '0;
                b_q[c]   <= '0;
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            ie_q    <= '0;
            done_q  <= '0;
            dbz_q   <= '0;
            sgn_q   <= '0;
            negq_q  <= '0;
            negr_q  <= '0;
            rdy_q   <= '1;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                st_q[c]  <= st_d[c];
                dvd_q[c] <= dvd_d[c];
                dvs_q[c] <= dvs_d[c];
                quo_q[c] <= quo_d[c];
                rem_q[c] <= rem_d[c];
                a_q[c]   <= a_d[c];
                b_q[c]   <= b_d[c];
                acc_q[c] <= acc_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            ie_q    <= ie_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign div_readdata = rdata_q;
    assign div_irq      = irq_q;
    assign div_rdy      = rdy_q;

endmodule

// File: tb/tb_div_avalon_mc.sv
// Bench for div_avalon_mc: directed scenarios plus randomized divisions checked against an
// arithmetic reference model (signed rules apply when AVDIV_SIGNED_EN is defined).
module tb_div_avalon_mc;
    localparam int W   = 32;
    localparam int CHW = 1;
    localparam int NCH = 1 << CHW;

`ifdef AVDIV_SIGNED_EN
    localparam bit TB_SGN = 1'b1;
`else
    localparam bit TB_SGN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [CHW+2:0] div_address;
    logic           div_chipselect;
    logic           div_read;
    logic           div_write;
    logic [W-1:0]   div_writedata;
    logic [W-1:0]   div_readdata;
    logic           div_irq;
    logic [NCH-1:0] div_rdy;

    int n_cmp = 0;
    int n_err = 0;

    div_avalon_mc #(.W(W), .CBIT(6), .CHW(CHW)) dut (
        .clk(clk), .reset(reset), .div_address(div_address),
        .div_chipselect(div_chipselect), .div_read(div_read), .div_write(div_write),
        .div_writedata(div_writedata), .div_readdata(div_readdata),
        .div_irq(div_irq), .div_rdy(div_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference: plain division with the divide-by-zero and overflow rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (s && TB_SGN) begin
            if (b == 0) begin
                q = (sa < 0) ? 1 : '1;
                r = a;
            end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            if (b == 0) begin
                q = '1;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Bus tasks are entered and left at a falling edge.
    task automatic bus_wr(input int ch, input int rg, input logic [W-1:0] d);
        div_chipselect = 1'b1;
        div_write      = 1'b1;
        div_address    = {ch[CHW-1:0], rg[2:0]};
        div_writedata  = d;
        @(negedge clk);
        div_chipselect = 1'b0;
        div_write      = 1'b0;
    endtask

    task automatic bus_rd(input int ch, input int rg, output logic [W-1:0] d);
        div_chipselect = 1'b1;
        div_read       = 1'b1;
        div_address    = {ch[CHW-1:0], rg[2:0]};
        @(negedge clk);
        d = div_readdata;
        div_chipselect = 1'b0;
        div_read       = 1'b0;
    endtask

    task automatic wait_rdy(input int ch, output int n);
        n = 0;
        while (!div_rdy[ch] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rdy_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input int ch, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit s);
        logic [W-1:0] q, r, d;
        int n;
        model(a, b, s, q, r);
        bus_wr(ch, 0, a);
        bus_wr(ch, 1, b);
        bus_wr(ch, 2, {30'd0, s, 1'b1});
        wait_rdy(ch, n);
        check({tag, "_lat"}, n, W + 2);
        bus_rd(ch, 2, d);
        check({tag, "_stat"}, d, {28'd0, s & TB_SGN, b == 0, 2'b11});
        bus_rd(ch, 3, d);
        check({tag, "_q"}, d, q);
        bus_rd(ch, 4, d);
        check({tag, "_r"}, d, r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d, a, b;
        int n, ch;
        bit s;
        reset = 1'b1;
        div_address = '0; div_chipselect = 1'b0; div_read = 1'b0; div_write = 1'b0;
        div_writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", div_readdata, 0);
        check("rst_irq", {31'd0, div_irq}, 0);
        check("rst_rdy", {30'd0, div_rdy}, 32'h3);
        reset = 1'b0;
        @(negedge clk);
        bus_rd(1, 2, d); check("rst_stat1", d, 32'h1);
        bus_rd(0, 3, d); check("rst_q0", d, 0);

        // T1 with exact latency measurement
        run_op("t1", 0, 100, 7, 0);

        // Busy: START and operand writes during a run; results hold until DONE
        bus_wr(0, 0, 200);
        bus_wr(0, 1, 9);
        bus_wr(0, 2, 1);
        bus_wr(0, 0, 50);
        bus_wr(0, 2, 1);
        bus_rd(0, 2, d); check("busy_stat", d, 0);
        bus_rd(0, 3, d); check("busy_qhold", d, 14);
        wait_rdy(0, n);
        bus_rd(0, 3, d); check("busy_q", d, 22);
        @(negedge clk);
        check("rdata_hold", div_readdata, 22);
        bus_rd(0, 4, d); check("busy_r", d, 2);
        bus_rd(0, 0, d); check("busy_dvd", d, 50);
        bus_rd(0, 6, d); check("rsvd6", d, 0);
        bus_wr(0, 5, '1);
        bus_rd(0, 5, d); check("ie_bit0", d, 1);
        bus_wr(0, 5, 0);

        // T2: overlapping channels
        bus_wr(0, 0, 32'hFFFF_FFFF);
        bus_wr(0, 1, 32'h10);
        bus_wr(1, 0, 50);
        bus_wr(1, 1, 5);
        bus_wr(0, 2, 1);
        bus_wr(1, 2, 1);
        wait_rdy(0, n);
        wait_rdy(1, n);
        bus_rd(0, 3, d); check("t2_q0", d, 32'h0FFF_FFFF);
        bus_rd(0, 4, d); check("t2_r0", d, 32'hF);
        bus_rd(1, 3, d); check("t2_q1", d, 10);
        bus_rd(1, 4, d); check("t2_r1", d, 0);

        // T3: divide by zero
        run_op("t3", 0, 32'h1234, 0, 0);

        // T4: interrupt
        bus_wr(1, 5, 1);
        bus_wr(1, 0, 9);
        bus_wr(1, 1, 3);
        bus_wr(1, 2, 1);
        wait_rdy(1, n);
        check("t4_irq_lag", {31'd0, div_irq}, 0);
        @(negedge clk);
        check("t4_irq_rise", {31'd0, div_irq}, 1);
        bus_rd(1, 3, d); check("t4_q", d, 3);
        bus_wr(1, 2, 1);
        @(negedge clk);
        check("t4_irq_start", {31'd0, div_irq}, 0);
        wait_rdy(1, n);
        @(negedge clk);
        check("t4_irq_again", {31'd0, div_irq}, 1);
        bus_wr(1, 5, 0);
        @(negedge clk);
        check("t4_irq_ie0", {31'd0, div_irq}, 0);

        // T5: reset mid-operation
        bus_wr(0, 0, 1000);
        bus_wr(0, 1, 3);
        bus_wr(0, 2, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rdy", {30'd0, div_rdy}, 32'h3);
        check("t5_rdata", div_readdata, 0);
        bus_rd(0, 2, d); check("t5_stat", d, 32'h1);
        bus_rd(0, 3, d); check("t5_q", d, 0);
        bus_rd(0, 4, d); check("t5_r", d, 0);
        run_op("t5_new", 0, 8, 3, 0);

        // T6: SGN=1 words (signed or unsigned depending on build)
        run_op("t6a", 0, -32'sd7, 2, 1);
        run_op("t6b", 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op("t6c", 0, -32'sd9, 0, 1);
        run_op("t6d", 1, 32'h8000_0000, 0, 1);

        // Randomized divisions
        for (int i = 0; i < 24; i++) begin
            ch = $urandom_range(0, NCH - 1);
            s  = $urandom_range(0, 1);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 255);
                3: begin a = 32'h8000_0000; b = '1; end
                default: ;
            endcase
            run_op("rnd", ch, a, b, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
